// File: rtl/sevseg_arbiter_if.sv
// rtl/sevseg_arbiter_if.sv - request/grant bus between requesters and the shared seven-segment arbiter
interface sevseg_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [6*N_REQ-1:0] req_value;
    logic [N_REQ-1:0]   grant;
    logic [N_REQ-1:0]   done;
    logic [5:0]         dec_in;
    logic               blank;
    logic               busy;

    modport master (
        output req, req_value,
        input  grant, done, dec_in, blank, busy
    );

    modport slave (
        input  req, req_value,
        output grant, done, dec_in, blank, busy
    );
endinterface

// File: rtl/sevseg_arbiter.sv
// rtl/sevseg_arbiter.sv - round-robin arbiter sharing one two-digit seven-segment decoder
// Optional SEVSEG_HOLD_EN: keep the last shown value lit between grants.
module sevseg_arbiter #(
    parameter int N_REQ = 4,
    parameter int DWELL = 50_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    sevseg_arbiter_if.slave bus
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(DWELL + 1);

    typedef enum logic [1:0] {IDLE, SHOW, DONE} state_t;

    state_t           state, stateNext;
    logic [PW-1:0]    ptr, ptrNext;
    logic [PW-1:0]    win, winNext;
    logic [CW-1:0]    cnt, cntNext;
    logic [N_REQ-1:0] grantQ, grantNext;
    logic [N_REQ-1:0] doneQ, doneNext;
    logic [5:0]       decQ, decNext;
    logic             blankQ, blankNext;
    logic             busyQ, busyNext;

    logic             found;
    logic [PW-1:0]    pick;
    int               idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            win    <= '0;
            cnt    <= '0;
            grantQ <= '0;
            doneQ  <= '0;
            decQ   <= '0;
            blankQ <= 1'b1;
            busyQ  <= 1'b0;
        end else begin
            state  <= stateNext;
            ptr    <= ptrNext;
            win    <= winNext;
            cnt    <= cntNext;
            grantQ <= grantNext;
            doneQ  <= doneNext;
            decQ   <= decNext;
            blankQ <= blankNext;
            busyQ  <= busyNext;
        end
    end

    // Rotating priority: first requester at or above ptr, wrapping at N_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    always_comb begin
        stateNext = state;
        ptrNext   = ptr;
        winNext   = win;
        cntNext   = cnt;
        grantNext = grantQ;
        doneNext  = '0;
        decNext   = decQ;
        blankNext = blankQ;
        busyNext  = busyQ;
        case (state)
            IDLE: begin
                if (found) begin
                    stateNext = SHOW;
                    winNext   = pick;
                    grantNext = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
                    decNext   = bus.req_value[int'(pick)*6 +: 6];
                    cntNext   = CW'(DWELL - 1);
                    blankNext = 1'b0;
                    busyNext  = 1'b1;
                end
            end
            SHOW: begin
                if (cnt == '0) begin
                    stateNext = DONE;
                    grantNext = '0;
                    doneNext  = {{(N_REQ-1){1'b0}}, 1'b1} << win;
                    ptrNext   = PW'((int'(win) + 1) % N_REQ);
`ifndef SEVSEG_HOLD_EN
                    blankNext = 1'b1;
                    decNext   = '0;
`endif
                end else begin
                    cntNext = cnt - 1'b1;
                end
            end
            DONE: begin
                stateNext = IDLE;
                busyNext  = 1'b0;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.grant  = grantQ;
    assign bus.done   = doneQ;
    assign bus.dec_in = decQ;
    assign bus.blank  = blankQ;
    assign bus.busy   = busyQ;
endmodule

// File: tb/tb_sevseg_arbiter.sv
// tb/tb_sevseg_arbiter.sv - directed-vector bench for sevseg_arbiter (DWELL=3 and DWELL=1 instances)
module tb_sevseg_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nTests = 0;
    int   nFail = 0;

    always #5 clk = ~clk;

    sevseg_arbiter_if #(.N_REQ(4)) ifA ();
    sevseg_arbiter_if #(.N_REQ(4)) ifB ();

    sevseg_arbiter #(.N_REQ(4), .DWELL(3)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));
    sevseg_arbiter #(.N_REQ(4), .DWELL(1)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));

`ifdef SEVSEG_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic serveA(input int idx, input logic [5:0] val, input bit dropAtDone, input bit midChange);
        tick();
        for (int c = 0; c < 3; c++) begin
            check("showGrant", ifA.grant, 32'(4'b0001 << idx));
            check("showDec", ifA.dec_in, 32'(val));
            check("showBlank", ifA.blank, 0);
            check("showBusy", ifA.busy, 1);
            if (midChange && c == 0) begin
                ifA.req[idx] = 1'b0;
                ifA.req_value[idx*6 +: 6] = 6'd50;
            end
            tick();
        end
        check("doneGrant", ifA.grant, 0);
        check("donePulse", ifA.done, 32'(4'b0001 << idx));
        check("doneBusy", ifA.busy, 1);
        check("doneBlank", ifA.blank, HOLD ? 0 : 1);
        check("doneDec", ifA.dec_in, HOLD ? 32'(val) : 0);
        if (dropAtDone) ifA.req[idx] = 1'b0;
        tick();
        check("idleDone", ifA.done, 0);
        check("idleBusy", ifA.busy, 0);
        check("idleGrant", ifA.grant, 0);
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        ifA.req = '0;
        ifA.req_value = '0;
        ifB.req = '0;
        ifB.req_value = '0;
        tick();
        tick();
        check("rstGrant", ifA.grant, 0);
        check("rstDone", ifA.done, 0);
        check("rstDec", ifA.dec_in, 0);
        check("rstBlank", ifA.blank, 1);
        check("rstBusy", ifA.busy, 0);
        rst_n = 1'b1;
        tick();

        // single requester, value 14
        ifA.req = 4'b0001;
        ifA.req_value[5:0] = 6'd14;
        serveA(0, 6'd14, 1'b1, 1'b0);
        tick();
        check("afterIdleGrant", ifA.grant, 0);
        check("afterBlank", ifA.blank, HOLD ? 0 : 1);
        check("afterDec", ifA.dec_in, HOLD ? 14 : 0);

        // all requesting: order 0,1,2,3,0 from a fresh pointer
        pulseReset();
        ifA.req_value = {6'd44, 6'd26, 6'd33, 6'd0};
        ifA.req = 4'b1111;
        serveA(0, 6'd0,  1'b0, 1'b0);
        serveA(1, 6'd33, 1'b0, 1'b0);
        serveA(2, 6'd26, 1'b0, 1'b0);
        serveA(3, 6'd44, 1'b0, 1'b0);
        serveA(0, 6'd0,  1'b1, 1'b0);

        // req1 drops and value changes mid-SHOW: window and value unaffected
        pulseReset();
        ifA.req = 4'b0010;
        ifA.req_value = {6'd0, 6'd0, 6'd7, 6'd0};
        serveA(1, 6'd7, 1'b0, 1'b1);
        tick();
        check("noRegrant", ifA.grant, 0);

        // reset mid-SHOW, then lowest index wins from pointer 0
        ifA.req = 4'b0100;
        ifA.req_value = {6'd0, 6'd5, 6'd0, 6'd0};
        tick();
        tick();
        check("preRstGrant", ifA.grant, 32'(4'b0100));
        rst_n = 1'b0;
        #1;
        check("midRstGrant", ifA.grant, 0);
        check("midRstDone", ifA.done, 0);
        check("midRstDec", ifA.dec_in, 0);
        check("midRstBlank", ifA.blank, 1);
        check("midRstBusy", ifA.busy, 0);
        ifA.req = 4'b1010;
        ifA.req_value = {6'd3, 6'd0, 6'd11, 6'd0};
        tick();
        check("heldRstDone", ifA.done, 0);
        rst_n = 1'b1;
        tick();
        check("postRstGrant", ifA.grant, 32'(4'b0010));
        check("postRstDec", ifA.dec_in, 11);
        ifA.req = '0;

        // DWELL=1 instance: period 3 with req held, then value 9 persistence
        ifB.req = 4'b1000;
        ifB.req_value = {6'd9, 6'd0, 6'd0, 6'd0};
        tick();
        check("d1Grant", ifB.grant, 32'(4'b1000));
        check("d1Dec", ifB.dec_in, 9);
        tick();
        check("d1DoneGrant", ifB.grant, 0);
        check("d1Done", ifB.done, 32'(4'b1000));
        tick();
        check("d1IdleGrant", ifB.grant, 0);
        check("d1IdleBusy", ifB.busy, 0);
        tick();
        check("d1Regrant", ifB.grant, 32'(4'b1000));
        tick();
        check("d1Done2", ifB.done, 32'(4'b1000));
        ifB.req = '0;
        tick();
        tick();
        check("d1HoldGrant", ifB.grant, 0);
        check("d1HoldBlank", ifB.blank, HOLD ? 0 : 1);
        check("d1HoldDec", ifB.dec_in, HOLD ? 9 : 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
